// File: rtl/mem_miss_handler_pkg.sv
// Shared types and constants for the cache-miss / memory-port arbiter.
// Imported by the port interface, the fill counter and the top level.
package mem_pkg;

    localparam int unsigned ADDR_W         = 16;
    localparam int unsigned DATA_W         = 16;
    localparam int unsigned BLOCK_WORDS    = 8;
    localparam int unsigned MEM_LATENCY    = 4;
    localparam int unsigned BLOCK_OFFSET_W = 4;
    localparam int unsigned WORD_IDX_W     = $clog2(BLOCK_WORDS);
    localparam int unsigned BLOCK_BYTES    = 2 ** BLOCK_OFFSET_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        FILL  = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_D = 1'b0,
        OWNER_I = 1'b1
    } owner_t;

    // Registered request presented on the memory port
    typedef struct packed {
        logic              en;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Strip the byte offset so the address names the start of its block
    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(BLOCK_BYTES - 1);
    endfunction

endpackage

// File: rtl/mem_miss_handler_if.sv
// Single pipelined main-memory port: request side driven by the miss handler,
// read return (fixed latency) driven by the memory.
interface mem_miss_handler_if #(
    parameter int unsigned ADDR_W = mem_pkg::ADDR_W,
    parameter int unsigned DATA_W = mem_pkg::DATA_W
);
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    modport master (
        output mem_en, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_rvalid
    );

    modport slave (
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_rvalid
    );
endinterface

// File: rtl/mem_miss_handler_fill_counter.sv
// Saturating block-word counter with sync clear; used once for issued
// requests and once for returned words during a block fill.
module fill_counter
    import mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    output logic [WORD_IDX_W-1:0] count,
    output logic                  last
);

    // Holds at the final word so a fill never wraps back to word 0
    assign last = (count == WORD_IDX_W'(BLOCK_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !last) begin
            count <= count + WORD_IDX_W'(1);
        end
    end

endmodule

// File: rtl/mem_miss_handler.sv
// Arbitrates the single memory port between D-cache stores, D-cache fills and
// I-cache fills; drives cache write strobes and pipeline stall requests.
module mem_miss_handler
    import mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_miss,
    input  logic [ADDR_W-1:0]     i_miss_addr,
    input  logic                  d_miss,
    input  logic [ADDR_W-1:0]     d_miss_addr,
    input  logic                  d_store,
    input  logic [ADDR_W-1:0]     d_store_addr,
    input  logic [DATA_W-1:0]     d_store_data,
    mem_miss_handler_if.master    mem,
    output logic [ADDR_W-1:0]     fill_addr,
    output logic [WORD_IDX_W-1:0] fill_word,
    output logic [DATA_W-1:0]     fill_data,
    output logic                  i_data_we,
    output logic                  d_data_we,
    output logic                  i_tag_we,
    output logic                  d_tag_we,
    output logic                  i_busy,
    output logic                  d_busy
);

    state_t                  state;
    owner_t                  owner;
    mem_req_t                req;

    logic                    in_fill;
    logic                    start_fill;
    logic                    accept;
    logic [ADDR_W-1:0]       miss_base;
    logic [ADDR_W-1:0]       next_issue_addr;

    logic [WORD_IDX_W-1:0]   issue_idx;
    logic                    issue_last;
    logic                    issue_en;
    logic [WORD_IDX_W-1:0]   ret_idx;
    logic                    ret_last;
    logic                    ret_en;

    assign in_fill    = (state == FILL);
    assign start_fill = (state == IDLE) && !d_store && (d_miss || i_miss);
    assign accept     = in_fill && mem.mem_rvalid;
    assign miss_base  = block_base(d_miss ? d_miss_addr : i_miss_addr);

    // Word index sits directly above the (always zero) halfword bit
    assign next_issue_addr = {fill_addr[ADDR_W-1:BLOCK_OFFSET_W],
                              issue_idx + WORD_IDX_W'(1), 1'b0};

    assign issue_en = in_fill && req.en && !issue_last;
    assign ret_en   = accept && !ret_last;

    fill_counter u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_fill),
        .en    (issue_en),
        .count (issue_idx),
        .last  (issue_last)
    );

    fill_counter u_ret_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_fill),
        .en    (ret_en),
        .count (ret_idx),
        .last  (ret_last)
    );

    // Arbitration and request sequencing; the first fill word is issued on
    // the detection edge so the port is busy from the very next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= OWNER_D;
            fill_addr <= '0;
            req       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req.en <= 1'b0;
                    req.wr <= 1'b0;
                    if (d_store) begin
                        state     <= STORE;
                        req.en    <= 1'b1;
                        req.wr    <= 1'b1;
                        req.addr  <= d_store_addr;
                        req.wdata <= d_store_data;
                    end else if (d_miss || i_miss) begin
                        state     <= FILL;
                        owner     <= d_miss ? OWNER_D : OWNER_I;
                        fill_addr <= miss_base;
                        req.en    <= 1'b1;
                        req.addr  <= miss_base;
                    end
                end
                STORE: begin
                    req.en <= 1'b0;
                    req.wr <= 1'b0;
                    state  <= IDLE;
                end
                FILL: begin
                    if (issue_last) begin
                        req.en <= 1'b0;
                    end else if (req.en) begin
                        req.addr <= next_issue_addr;
                    end
                    if (accept && ret_last) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mem.mem_en    = req.en;
    assign mem.mem_wr    = req.wr;
    assign mem.mem_addr  = req.addr;
    assign mem.mem_wdata = req.wdata;

    // Returns are written the cycle they arrive; strays outside FILL are dropped
    assign fill_word = ret_idx;
    assign fill_data = mem.mem_rdata;
    assign i_data_we = accept && (owner == OWNER_I);
    assign d_data_we = accept && (owner == OWNER_D);
    assign i_tag_we  = i_data_we && ret_last;
    assign d_tag_we  = d_data_we && ret_last;

    // Stall in the detection cycle; an I miss losing arbitration is already covered by i_miss
    assign i_busy = i_miss || (in_fill && (owner == OWNER_I));
    assign d_busy = d_miss || (in_fill && (owner == OWNER_D));

endmodule

// File: tb/tb_mem_miss_handler.sv
// Scoreboard bench for mem_miss_handler: expected memory requests and cache
// strobes are queued by the stimulus and popped by a negedge monitor.
module tb_mem_miss_handler;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_miss = 1'b0, d_miss = 1'b0, d_store = 1'b0;
    logic [15:0] i_miss_addr = '0, d_miss_addr = '0, d_store_addr = '0, d_store_data = '0;
    logic [15:0] fill_addr, fill_data;
    logic [2:0]  fill_word;
    logic        i_data_we, d_data_we, i_tag_we, d_tag_we, i_busy, d_busy;

    mem_miss_handler_if mem_bus ();

    mem_miss_handler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_miss       (i_miss),
        .i_miss_addr  (i_miss_addr),
        .d_miss       (d_miss),
        .d_miss_addr  (d_miss_addr),
        .d_store      (d_store),
        .d_store_addr (d_store_addr),
        .d_store_data (d_store_data),
        .mem          (mem_bus),
        .fill_addr    (fill_addr),
        .fill_word    (fill_word),
        .fill_data    (fill_data),
        .i_data_we    (i_data_we),
        .d_data_we    (d_data_we),
        .i_tag_we     (i_tag_we),
        .d_tag_we     (d_tag_we),
        .i_busy       (i_busy),
        .d_busy       (d_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {int cyc; logic wr; logic [15:0] addr; logic [15:0] wdata;} req_t;
    typedef struct {int cyc; logic is_i; logic [2:0] word; logic [15:0] data; logic tag;} wr_t;
    req_t req_q[$];
    wr_t  wr_q[$];
    req_t mon_r;
    wr_t  mon_w;

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_req(input int c, input logic wr, input logic [15:0] a, input logic [15:0] d);
        req_t r;
        r.cyc = c; r.wr = wr; r.addr = a; r.wdata = d;
        req_q.push_back(r);
    endtask

    task automatic push_wr(input int c, input logic is_i, input int k, input logic [15:0] a);
        wr_t w;
        w.cyc = c; w.is_i = is_i; w.word = 3'(k); w.data = mdata(a); w.tag = (k == 7);
        wr_q.push_back(w);
    endtask

    // Miss detected in cycle t: requests t+1..t+8, returns t+5..t+12
    task automatic push_fill(input int t, input logic [15:0] base, input logic is_i);
        for (int k = 0; k < 8; k++) begin
            push_req(t + 1 + k, 1'b0, base + 16'(2 * k), 16'h0);
            push_wr(t + 5 + k, is_i, k, base + 16'(2 * k));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: 4-cycle read latency, plus a stray-valid override
    logic        ret_v [16] = '{default: 1'b0};
    logic [15:0] ret_a [16];
    logic        stray = 1'b1;

    always @(negedge clk) begin
        ret_v[cyc % 16] = 1'b0;
        if (mem_bus.mem_en === 1'b1 && mem_bus.mem_wr === 1'b0) begin
            ret_v[(cyc + 4) % 16] = 1'b1;
            ret_a[(cyc + 4) % 16] = mem_bus.mem_addr;
        end
    end

    initial begin
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 16'hDEAD;
        forever begin
            @(posedge clk);
            #1;
            mem_bus.mem_rvalid = ret_v[cyc % 16] | stray;
            mem_bus.mem_rdata  = ret_v[cyc % 16] ? mdata(ret_a[cyc % 16]) : 16'hDEAD;
        end
    end

    // Monitor: every request and every strobe must match the queue head
    always @(negedge clk) begin
        if (mem_bus.mem_en !== 1'b0) begin
            if (req_q.size() == 0) begin
                chk("spurious_req", {16'(cyc), mem_bus.mem_addr}, 0);
            end else begin
                mon_r = req_q.pop_front();
                chk("mem_req",
                    {16'(cyc), mem_bus.mem_wr, mem_bus.mem_addr, mon_r.wr ? mem_bus.mem_wdata : 16'h0},
                    {16'(mon_r.cyc), mon_r.wr, mon_r.addr, mon_r.wr ? mon_r.wdata : 16'h0});
            end
        end
        if ({i_data_we, d_data_we, i_tag_we, d_tag_we} !== 4'b0) begin
            if (wr_q.size() == 0) begin
                chk("spurious_strobe", {16'(cyc), i_data_we, d_data_we, i_tag_we, d_tag_we}, 0);
            end else begin
                mon_w = wr_q.pop_front();
                chk("fill_strobe",
                    {16'(cyc), i_data_we, d_data_we, i_tag_we, d_tag_we, fill_word, fill_data},
                    {16'(mon_w.cyc), mon_w.is_i, !mon_w.is_i, mon_w.is_i & mon_w.tag,
                     !mon_w.is_i & mon_w.tag, mon_w.word, mon_w.data});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        // Reset held with stray returns present
        repeat (3) tick();
        @(negedge clk);
        chk("reset_outputs",
            {mem_bus.mem_en, mem_bus.mem_wr, mem_bus.mem_addr, mem_bus.mem_wdata, fill_addr,
             fill_word, i_data_we, d_data_we, i_tag_we, d_tag_we, i_busy, d_busy}, 0);
        i_miss = 1'b1;
        #1;
        chk("reset_busy_follows_miss", {i_busy, d_busy}, 2'b10);
        tick();
        i_miss = 1'b0;
        rst_n  = 1'b1;
        stray  = 1'b0;
        repeat (2) tick();

        // D miss at 0x1236
        t = cyc;
        d_miss = 1'b1; d_miss_addr = 16'h1236;
        push_fill(t, 16'h1230, 1'b0);
        @(negedge clk);
        chk("d_busy_detect", d_busy, 1);
        tick();
        d_miss = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk("d_busy_fill", d_busy, 1);
            tick();
        end
        @(negedge clk);
        chk("d_busy_released", {d_busy, mem_bus.mem_en}, 0);
        chk("d_fill_addr", fill_addr, 16'h1230);
        repeat (3) tick();

        // Simultaneous I and D misses: D first, I waits
        t = cyc;
        i_miss = 1'b1; i_miss_addr = 16'h0040;
        d_miss = 1'b1; d_miss_addr = 16'h8000;
        push_fill(t, 16'h8000, 1'b0);
        push_fill(t + 13, 16'h0040, 1'b1);
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            chk("i_busy_waiting", i_busy, 1);
            chk("d_busy_first", d_busy, 64'(c <= 12));
            tick();
            if (c == 0) d_miss = 1'b0;
        end
        i_miss = 1'b0;
        for (int c = 14; c <= 25; c++) begin
            @(negedge clk);
            chk("i_busy_fill", i_busy, 1);
            tick();
        end
        @(negedge clk);
        chk("i_busy_released", i_busy, 0);
        chk("i_fill_addr", fill_addr, 16'h0040);
        repeat (3) tick();

        // Store wins over a concurrent I miss
        t = cyc;
        d_store = 1'b1; d_store_addr = 16'h2002; d_store_data = 16'hBEEF;
        i_miss = 1'b1; i_miss_addr = 16'h0106;
        push_req(t + 1, 1'b1, 16'h2002, 16'hBEEF);
        push_fill(t + 2, 16'h0100, 1'b1);
        @(negedge clk);
        chk("i_busy_vs_store", {i_busy, d_busy}, 2'b10);
        tick();
        d_store = 1'b0;
        @(negedge clk);
        chk("store_cycle_busy", {i_busy, d_busy}, 2'b10);
        repeat (2) tick();
        i_miss = 1'b0;
        repeat (14) tick();

        // Reset pulsed mid-fill: word 0 lands, later returns are dropped
        t = cyc;
        d_miss = 1'b1; d_miss_addr = 16'h4458;
        for (int k = 0; k < 5; k++) push_req(t + 1 + k, 1'b0, 16'h4450 + 16'(2 * k), 16'h0);
        push_wr(t + 5, 1'b0, 0, 16'h4450);
        tick();
        d_miss = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midfill_reset_outputs",
            {mem_bus.mem_en, i_data_we, d_data_we, i_tag_we, d_tag_we, d_busy, fill_addr}, 0);
        tick();
        rst_n = 1'b1;
        for (int c = 7; c <= 9; c++) begin
            @(negedge clk);
            chk("late_return_ignored", {i_data_we, d_data_we, i_tag_we, d_tag_we, mem_bus.mem_en}, 0);
            tick();
        end
        repeat (2) tick();

        // Stray valid while idle
        stray = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge clk);
            chk("stray_rvalid_ignored", {i_data_we, d_data_we, i_tag_we, d_tag_we}, 0);
        end
        stray = 1'b0;
        repeat (3) tick();

        chk("req_queue_drained", 64'(req_q.size()), 0);
        chk("strobe_queue_drained", 64'(wr_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
